// File: rtl/controle_ula_multiciclo_pkg.sv
// Shared definitions for the multi-cycle ALU control:
// ALU operation codes, ALUOp encodings and FSM states.
package controle_ula_multiciclo_pkg;

   // ALU operation codes (3-bit, zero-extended to CTRL_W at the output)
   localparam logic [2:0] ULA_AND = 3'b000;
   localparam logic [2:0] ULA_OR  = 3'b001;
   localparam logic [2:0] ULA_ADD = 3'b010;
   localparam logic [2:0] ULA_SLL = 3'b011;
   localparam logic [2:0] ULA_SRL = 3'b100;
   localparam logic [2:0] ULA_NOR = 3'b101;
   localparam logic [2:0] ULA_SUB = 3'b110;
   localparam logic [2:0] ULA_SLT = 3'b111;

   // ALUOp encodings from the main control unit
   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_SUB = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   // Controller states: idle/accepting, or stepping a shift
   typedef enum logic {
      OCIOSO  = 1'b0,
      DESLOCA = 1'b1
   } estado_t;

   // True for the ops that the iterative shifter executes one bit per cycle
   function automatic logic eh_deslocamento(input logic [2:0] code);
      return (code == ULA_SLL) || (code == ULA_SRL);
   endfunction

endpackage

// File: rtl/controle_ula_multiciclo_decodificador_ula.sv
// Combinational decode of (ALUOp, funct, fv) into a 3-bit ALU code,
// a shift flag and an illegal-encoding flag (illegal ops decode as ADD).
module decodificador_ula
   import controle_ula_multiciclo_pkg::*;
#(
   parameter int FUNCT_W = 3,
   parameter int FV_W    = 3
) (
   input  logic [1:0]         ALUOp,
   input  logic [FUNCT_W-1:0] funct,
   input  logic [FV_W-1:0]    fv,
   output logic [2:0]         code,
   output logic               eh_shift,
   output logic               ilegal
);

   // Only the low 3 bits carry the operation; any set upper bit is illegal
   logic funct_alto, fv_alto;
   assign funct_alto = (funct >> 3) != '0;
   assign fv_alto    = (fv >> 3) != '0;

   // Decode table; defaults give ADD, non-shift, legal
   always_comb begin
      code   = ULA_ADD;
      ilegal = 1'b0;
      case (ALUOp)
         ALUOP_ADD: code = ULA_ADD;
         ALUOP_SUB: code = ULA_SUB;
         ALUOP_R: begin
            if (funct_alto) begin
               ilegal = 1'b1;
            end else begin
               case (funct[2:0])
                  3'b000:  code = ULA_ADD;
                  3'b001:  code = ULA_SUB;
                  3'b010:  code = ULA_AND;
                  3'b011:  code = ULA_OR;
                  3'b100:  code = ULA_SLT;
                  3'b101:  code = ULA_SLL;
                  3'b110:  code = ULA_SRL;
                  default: code = ULA_NOR;
               endcase
            end
         end
         default: begin
            if (fv_alto) begin
               ilegal = 1'b1;
            end else begin
               case (fv[2:0])
                  3'b000:  code = ULA_ADD;
                  3'b001:  code = ULA_AND;
                  3'b010:  code = ULA_OR;
                  3'b011:  code = ULA_SLT;
                  3'b100:  code = ULA_SLL;
                  3'b101:  code = ULA_SRL;
                  default: ilegal = 1'b1;
               endcase
            end
         end
      endcase
      eh_shift = eh_deslocamento(code);
   end

endmodule

// File: rtl/controle_ula_multiciclo.sv
// Registered ALU control for the multi-cycle nRISC EX stage.
// Single-cycle ops complete the cycle after acceptance; shifts run one
// 1-bit step per cycle with ocupado stalling upstream until the last step.
module controle_ula_multiciclo
   import controle_ula_multiciclo_pkg::*;
#(
   parameter int FUNCT_W = 3,
   parameter int FV_W    = 3,
   parameter int CTRL_W  = 3,
   parameter int SHAMT_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valido_in,
   input  logic               descarta,
   input  logic [1:0]         ALUOp,
   input  logic [FUNCT_W-1:0] funct,
   input  logic [FV_W-1:0]    fv,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [CTRL_W-1:0]  ALUcontrol,
   output logic               valido_out,
   output logic               ocupado,
   output logic               passo,
   output logic               ultimo,
   output logic               ilegal
);

   estado_t              estado, estado_prox;
   logic [SHAMT_W-1:0]   cnt, cnt_prox;
   logic [CTRL_W-1:0]    ctrl_prox;
   logic                 valido_prox, ocupado_prox, passo_prox, ultimo_prox, ilegal_prox;

   logic [2:0]           cod_dec;
   logic                 shift_dec, ilegal_dec;

   decodificador_ula #(
      .FUNCT_W (FUNCT_W),
      .FV_W    (FV_W)
   ) u_dec (
      .ALUOp    (ALUOp),
      .funct    (funct),
      .fv       (fv),
      .code     (cod_dec),
      .eh_shift (shift_dec),
      .ilegal   (ilegal_dec)
   );

   // Next state, step counter and next registered outputs
   always_comb begin
      estado_prox  = estado;
      cnt_prox     = cnt;
      ctrl_prox    = ALUcontrol;
      valido_prox  = 1'b0;
      ocupado_prox = 1'b0;
      passo_prox   = 1'b0;
      ultimo_prox  = 1'b0;
      ilegal_prox  = 1'b0;
      case (estado)
         OCIOSO: begin
            if (valido_in && !descarta) begin
               ctrl_prox = CTRL_W'(cod_dec);
               if (shift_dec && (shamt != '0)) begin
                  // First step is presented the cycle after acceptance
                  estado_prox  = DESLOCA;
                  cnt_prox     = shamt;
                  passo_prox   = 1'b1;
                  ocupado_prox = 1'b1;
                  ultimo_prox  = (shamt == SHAMT_W'(1));
                  valido_prox  = (shamt == SHAMT_W'(1));
               end else begin
                  valido_prox = 1'b1;
                  ilegal_prox = ilegal_dec;
               end
            end
         end
         default: begin
            // cnt holds the number of steps left including the current one
            if (descarta || (cnt == SHAMT_W'(1))) begin
               estado_prox = OCIOSO;
               cnt_prox    = '0;
            end else begin
               cnt_prox     = cnt - SHAMT_W'(1);
               passo_prox   = 1'b1;
               ocupado_prox = 1'b1;
               ultimo_prox  = (cnt == SHAMT_W'(2));
               valido_prox  = (cnt == SHAMT_W'(2));
            end
         end
      endcase
   end

   // State, counter and output registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado     <= OCIOSO;
         cnt        <= '0;
         ALUcontrol <= '0;
         valido_out <= 1'b0;
         ocupado    <= 1'b0;
         passo      <= 1'b0;
         ultimo     <= 1'b0;
         ilegal     <= 1'b0;
      end else begin
         estado     <= estado_prox;
         cnt        <= cnt_prox;
         ALUcontrol <= ctrl_prox;
         valido_out <= valido_prox;
         ocupado    <= ocupado_prox;
         passo      <= passo_prox;
         ultimo     <= ultimo_prox;
         ilegal     <= ilegal_prox;
      end
   end

endmodule

// File: tb/tb_controle_ula_multiciclo.sv
// Directed bench for the multi-cycle ALU control.
module tb_controle_ula_multiciclo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valido_in, descarta;
   logic [1:0] ALUOp;
   logic [2:0] funct, fv, shamt;
   logic [2:0] ALUcontrol;
   logic       valido_out, ocupado, passo, ultimo, ilegal;

   int total  = 0;
   int passou = 0;

   controle_ula_multiciclo #(
      .FUNCT_W (3),
      .FV_W    (3),
      .CTRL_W  (3),
      .SHAMT_W (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valido_in  (valido_in),
      .descarta   (descarta),
      .ALUOp      (ALUOp),
      .funct      (funct),
      .fv         (fv),
      .shamt      (shamt),
      .ALUcontrol (ALUcontrol),
      .valido_out (valido_out),
      .ocupado    (ocupado),
      .passo      (passo),
      .ultimo     (ultimo),
      .ilegal     (ilegal)
   );

   always #5 clk = ~clk;

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      total++;
      assert (obs === esp) passou++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, esp);
   endtask

   task automatic confere(input string tag, input logic [2:0] ctrl, input logic vo,
                          input logic oc, input logic pa, input logic ul, input logic il);
      verifica({tag, ".ALUcontrol"}, 32'(ALUcontrol), 32'(ctrl));
      verifica({tag, ".valido_out"}, 32'(valido_out), 32'(vo));
      verifica({tag, ".ocupado"},    32'(ocupado),    32'(oc));
      verifica({tag, ".passo"},      32'(passo),      32'(pa));
      verifica({tag, ".ultimo"},     32'(ultimo),     32'(ul));
      verifica({tag, ".ilegal"},     32'(ilegal),     32'(il));
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic ciclo();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; valido_in = 1'b0; descarta = 1'b0;
      ALUOp = 2'b00; funct = 3'b000; fv = 3'b000; shamt = 3'b000;
      #3;
      confere("reset", 3'b000, 0, 0, 0, 0, 0);
      ciclo(); ciclo();
      rst_n = 1'b1;
      ciclo();
      confere("idle_after_reset", 3'b000, 0, 0, 0, 0, 0);

      // ld/st ADD
      ALUOp = 2'b00; valido_in = 1'b1;
      ciclo(); valido_in = 1'b0;
      confere("add", 3'b010, 1, 0, 0, 0, 0);
      ciclo();
      confere("add_idle_hold", 3'b010, 0, 0, 0, 0, 0);

      // R-type SUB then I-type SLT back-to-back
      ALUOp = 2'b10; funct = 3'b001; valido_in = 1'b1;
      ciclo();
      confere("r_sub", 3'b110, 1, 0, 0, 0, 0);
      ALUOp = 2'b11; fv = 3'b011;
      ciclo(); valido_in = 1'b0;
      confere("i_slt", 3'b111, 1, 0, 0, 0, 0);
      ciclo();
      confere("slt_idle", 3'b111, 0, 0, 0, 0, 0);

      // R-type SLL shamt=3; an ADD offered while busy must be ignored
      ALUOp = 2'b10; funct = 3'b101; shamt = 3'd3; valido_in = 1'b1;
      ciclo();
      ALUOp = 2'b00;
      confere("sll3_step1", 3'b011, 0, 1, 1, 0, 0);
      ciclo();
      confere("sll3_step2", 3'b011, 0, 1, 1, 0, 0);
      ciclo();
      valido_in = 1'b0;
      confere("sll3_step3", 3'b011, 1, 1, 1, 1, 0);
      ciclo();
      confere("sll3_done", 3'b011, 0, 0, 0, 0, 0);

      // Illegal fv decodes as ADD; then SRL with shamt=0 is single-cycle
      ALUOp = 2'b11; fv = 3'b110; valido_in = 1'b1;
      ciclo();
      confere("fv_ilegal", 3'b010, 1, 0, 0, 0, 1);
      ALUOp = 2'b10; funct = 3'b110; shamt = 3'd0;
      ciclo(); valido_in = 1'b0;
      confere("srl_shamt0", 3'b100, 1, 0, 0, 0, 0);
      ciclo();
      confere("srl0_idle", 3'b100, 0, 0, 0, 0, 0);

      // I-type SLL shamt=7 flushed during step 2
      ALUOp = 2'b11; fv = 3'b100; shamt = 3'd7; valido_in = 1'b1;
      ciclo(); valido_in = 1'b0;
      confere("sll7_step1", 3'b011, 0, 1, 1, 0, 0);
      ciclo(); descarta = 1'b1;
      confere("sll7_step2", 3'b011, 0, 1, 1, 0, 0);
      ciclo(); descarta = 1'b0;
      confere("sll7_flushed", 3'b011, 0, 0, 0, 0, 0);
      ciclo();
      confere("flush_stays_idle", 3'b011, 0, 0, 0, 0, 0);
      ALUOp = 2'b01; valido_in = 1'b1;
      ciclo(); valido_in = 1'b0;
      confere("sub_after_flush", 3'b110, 1, 0, 0, 0, 0);

      // descarta blocks acceptance while idle
      ALUOp = 2'b00; valido_in = 1'b1; descarta = 1'b1;
      ciclo(); valido_in = 1'b0; descarta = 1'b0;
      confere("descarta_blocks", 3'b110, 0, 0, 0, 0, 0);

      // SRL with shamt=7 runs exactly 7 steps
      ALUOp = 2'b10; funct = 3'b110; shamt = 3'd7; valido_in = 1'b1;
      ciclo(); valido_in = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         confere($sformatf("srl7_step%0d", i), 3'b100, (i == 7), 1, 1, (i == 7), 0);
         ciclo();
      end
      confere("srl7_done", 3'b100, 0, 0, 0, 0, 0);

      // Reset asserted during step 2 of a 5-step SLL
      ALUOp = 2'b10; funct = 3'b101; shamt = 3'd5; valido_in = 1'b1;
      ciclo(); valido_in = 1'b0;
      confere("sll5_step1", 3'b011, 0, 1, 1, 0, 0);
      ciclo();
      confere("sll5_step2", 3'b011, 0, 1, 1, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      confere("async_reset", 3'b000, 0, 0, 0, 0, 0);
      ciclo(); ciclo();
      rst_n = 1'b1;
      ciclo();
      confere("after_reset_idle", 3'b000, 0, 0, 0, 0, 0);
      ALUOp = 2'b00; valido_in = 1'b1;
      ciclo(); valido_in = 1'b0;
      confere("accept_after_reset", 3'b010, 1, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", passou, total);
      $finish;
   end

endmodule
